// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences PC, IR, register file, ALU and the unified
// memory port, waits on memory ready, and counts retired instructions.
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state, state_next;
  logic             retire_c;
  logic             set_illegal_c;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             legal_c;

  assign legal_c = (opcode_i == OP_R) || (opcode_i == OP_I) || (opcode_i == OP_LOAD) ||
                   (opcode_i == OP_STORE) || (opcode_i == OP_BRANCH);

  // State, sticky illegal flag and retire counter
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_next;
      if (set_illegal_c) illegal_q <= 1'b1;
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_next    = state;
    retire_c      = 1'b0;
    set_illegal_c = 1'b0;
    pc_write_o    = 1'b0;
    pc_src_o      = 1'b0;
    iord_o        = 1'b0;
    ir_write_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // PC + (imm<<1) lands in ALUOut for a possible branch
        alu_src_b_o = 2'b11;
        if (legal_c) begin
          state_next = S_EXEC;
        end else begin
          state_next    = S_HALT;
          set_illegal_c = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        case (opcode_i)
          OP_R: begin
            alu_op_o   = 2'b10;
            state_next = S_WB;
          end
          OP_I: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 2'b10;
            state_next  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_o = 2'b10;
            state_next  = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_o   = 2'b01;
            pc_src_o   = 1'b1;
            pc_write_o = zero_i;
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        iord_o = 1'b1;
        if (opcode_i == OP_LOAD) begin
          mem_read_o = 1'b1;
          if (mem_ready_i) state_next = S_WB;
        end else if (opcode_i == OP_STORE) begin
          mem_write_o = 1'b1;
          if (mem_ready_i) begin
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (opcode_i == OP_LOAD);
        retire_c     = 1'b1;
        state_next   = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  assign illegal_o = illegal_q;
  assign retired_o = retired_q;
  assign state_o   = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Cycle-accurate scoreboard bench for multi_cycle_ctrl, built with a 4-bit retire counter.
module tb_multi_cycle_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // {state, pc_write pc_src iord ir_write mem_read mem_write mem_to_reg reg_write alu_src_a, alu_src_b, alu_op, illegal}
  localparam logic [16:0] V_F_WAIT = {3'd0, 9'b000010000, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] V_F_RDY  = {3'd0, 9'b100110000, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] V_DEC    = {3'd1, 9'b000000000, 2'b11, 2'b00, 1'b0};
  localparam logic [16:0] V_EX_R   = {3'd2, 9'b000000001, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] V_EX_I   = {3'd2, 9'b000000001, 2'b10, 2'b10, 1'b0};
  localparam logic [16:0] V_EX_LS  = {3'd2, 9'b000000001, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] V_EX_BT  = {3'd2, 9'b110000001, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] V_EX_BN  = {3'd2, 9'b010000001, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] V_MEM_LD = {3'd3, 9'b001010000, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_MEM_ST = {3'd3, 9'b001001000, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_WB_ALU = {3'd4, 9'b000000010, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_WB_LD  = {3'd4, 9'b000000110, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_HALT   = {3'd5, 9'b000000000, 2'b00, 2'b00, 1'b1};

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [16:0] exp;
    logic        ret;
  } item_t;

  logic             clk, nrst, zero, mem_ready;
  logic [6:0]       opcode;
  logic             pc_write, pc_src, iord, ir_write, mem_read, mem_write;
  logic             mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]       alu_src_b, alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [16:0]      ctrl;

  item_t      stim_q[$];
  item_t      exp_q[$];
  item_t      it;
  logic [3:0] ret_exp;
  int         checks, errors, cyc;

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .nrst_i(nrst), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_src_o(pc_src), .iord_o(iord), .ir_write_o(ir_write),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg),
    .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .illegal_o(illegal), .state_o(state), .retired_o(retired)
  );

  assign ctrl = {state, pc_write, pc_src, iord, ir_write, mem_read, mem_write, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [16:0] exp, input logic ret);
    item_t n;
    n.op = op; n.zero = z; n.rdy = rdy; n.exp = exp; n.ret = ret;
    stim_q.push_back(n);
  endtask

  // Expected per-cycle sequence of one instruction with the given wait states
  task automatic push_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) add(op, z, 1'b0, V_F_WAIT, 1'b0);
    add(op, z, 1'b1, V_F_RDY, 1'b0);
    add(op, z, 1'($urandom), V_DEC, 1'b0);
    case (op)
      OP_R: begin
        add(op, z, 1'($urandom), V_EX_R, 1'b0);
        add(op, z, 1'($urandom), V_WB_ALU, 1'b1);
      end
      OP_I: begin
        add(op, z, 1'($urandom), V_EX_I, 1'b0);
        add(op, z, 1'($urandom), V_WB_ALU, 1'b1);
      end
      OP_LOAD: begin
        add(op, z, 1'($urandom), V_EX_LS, 1'b0);
        for (int i = 0; i < mw; i++) add(op, z, 1'b0, V_MEM_LD, 1'b0);
        add(op, z, 1'b1, V_MEM_LD, 1'b0);
        add(op, z, 1'($urandom), V_WB_LD, 1'b1);
      end
      OP_STORE: begin
        add(op, z, 1'($urandom), V_EX_LS, 1'b0);
        for (int i = 0; i < mw; i++) add(op, z, 1'b0, V_MEM_ST, 1'b0);
        add(op, z, 1'b1, V_MEM_ST, 1'b1);
      end
      OP_BRANCH: add(op, z, 1'($urandom), z ? V_EX_BT : V_EX_BN, 1'b1);
      default: ;
    endcase
  endtask

  task automatic test_reset();
    nrst = 1'b0; mem_ready = 1'b0; opcode = OP_R; zero = 1'b0;
    #2;
    checks++;
    if (ctrl !== V_F_WAIT || retired !== 4'd0) begin
      errors++;
      $display("FAIL reset_init: ctrl=%h retired=%0d, required ctrl=%h retired=0", ctrl, retired, V_F_WAIT);
    end
    #6 nrst = 1'b1;
    @(posedge clk); #1;
    ret_exp = 4'd0;
    push_instr(OP_BRANCH, 1'b1, 0, 0);
    add(OP_R, 1'b0, 1'b1, V_F_RDY, 1'b0);
    add(OP_R, 1'b0, 1'b0, V_DEC, 1'b0);
    add(OP_R, 1'b0, 1'b0, V_EX_R, 1'b0);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL reset_pre cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      if (stim_q.size() > 0) begin
        @(posedge clk); #1;
        if (it.ret) ret_exp++;
      end
      cyc++;
    end
    // Now past the EXEC negedge; drop reset between edges
    mem_ready = 1'b0;
    #1 nrst = 1'b0;
    #1;
    ret_exp = 4'd0;
    checks++;
    if (ctrl !== V_F_WAIT || retired !== ret_exp) begin
      errors++;
      $display("FAIL reset_mid_exec: ctrl=%h retired=%0d, required ctrl=%h retired=0", ctrl, retired, V_F_WAIT);
    end
    #2 nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ctrl !== V_F_WAIT || retired !== ret_exp) begin
      errors++;
      $display("FAIL reset_release: ctrl=%h retired=%0d, required ctrl=%h retired=0", ctrl, retired, V_F_WAIT);
    end
  endtask

  task automatic test_r_type();
    push_instr(OP_R, 1'b0, 0, 0);
    push_instr(OP_I, 1'b1, 0, 0);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL r_type cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      @(posedge clk); #1;
      if (it.ret) ret_exp++;
      cyc++;
    end
  endtask

  task automatic test_load_wait();
    push_instr(OP_LOAD, 1'b0, 2, 3);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL load_wait cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      @(posedge clk); #1;
      if (it.ret) ret_exp++;
      cyc++;
    end
  endtask

  task automatic test_branch();
    push_instr(OP_BRANCH, 1'b1, 0, 0);
    push_instr(OP_BRANCH, 1'b0, 0, 0);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL branch cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      @(posedge clk); #1;
      if (it.ret) ret_exp++;
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    push_instr(OP_STORE, 1'b0, 1, 2);
    push_instr(OP_LOAD, 1'b1, 0, 0);
    push_instr(OP_STORE, 1'b1, 0, 0);
    push_instr(OP_I, 1'b0, 3, 0);
    push_instr(OP_R, 1'b1, 1, 0);
    push_instr(OP_LOAD, 1'b0, 0, 1);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      @(posedge clk); #1;
      if (it.ret) ret_exp++;
      cyc++;
    end
  endtask

  task automatic test_illegal();
    push_instr(OP_BAD, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) add(OP_BAD, 1'($urandom), 1'($urandom), V_HALT, 1'b0);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL illegal cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      @(posedge clk); #1;
      if (it.ret) ret_exp++;
      cyc++;
    end
    mem_ready = 1'b0;
    #2 nrst = 1'b0;
    #1;
    ret_exp = 4'd0;
    checks++;
    if (ctrl !== V_F_WAIT || retired !== ret_exp) begin
      errors++;
      $display("FAIL illegal_clear: ctrl=%h retired=%0d, required ctrl=%h retired=0", ctrl, retired, V_F_WAIT);
    end
    #3 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++)
      push_instr((i % 2 == 0) ? OP_STORE : OP_BRANCH, 1'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      opcode = it.op; zero = it.zero; mem_ready = it.rdy;
      exp_q.push_back(it);
      @(negedge clk);
      it = exp_q.pop_front();
      checks++;
      if (ctrl !== it.exp || retired !== ret_exp) begin
        errors++;
        $display("FAIL wrap cyc %0d: ctrl=%h retired=%0d, required ctrl=%h retired=%0d", cyc, ctrl, retired, it.exp, ret_exp);
      end
      @(posedge clk); #1;
      if (it.ret) ret_exp++;
      cyc++;
    end
    checks++;
    if (retired !== 4'd1 || state !== 3'd0) begin
      errors++;
      $display("FAIL wrap_final: retired=%0d state=%0d, required retired=1 state=0", retired, state);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ret_exp = 4'd0;
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Finite-state controller that sequences a shared-resource RISC-V datapath over multiple cycles per instruction. The datapath has one ALU, one unified instruction/data memory port and one register file. The block decodes the latched opcode and drives every enable and mux select for PC, IR, register file, ALU and memory. It handles a variable-latency memory via a ready handshake and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk_i  input  1  clock, all state on rising edge
- nrst_i  input  1  reset, asynchronous, active-low
- opcode_i  input  7  opcode field from IR output (instr[6:0]); valid from DECODE onward
- zero_i  input  1  ALU zero flag
- mem_ready_i  input  1  memory completes current access this cycle
- pc_write_o  output  1  load PC
- pc_src_o  output  1  PC source: 0 = ALU result (PC+4), 1 = ALUOut register (branch target)
- iord_o  output  1  memory address: 0 = PC, 1 = ALUOut
- ir_write_o  output  1  load IR
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- mem_to_reg_o  output  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_write_o  output  1  register file write enable
- alu_src_a_o  output  1  ALU A: 0 = PC, 1 = rs1
- alu_src_b_o  output  2  ALU B: 00 = rs2, 01 = constant 4, 10 = imm, 11 = imm<<1
- alu_op_o  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- illegal_o  output  1  sticky unsupported-opcode flag
- state_o  output  3  current state encoding
- retired_o  output  CNT_W  retired-instruction count

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6–7 are unreachable and recover to FETCH.
- Supported opcodes:
  - R = 0110011
  - I-ALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011 (beq)
- Default for every output is 0 in every state unless listed below.
- FETCH:
  - iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready_i=1: ir_write=1, pc_write=1, pc_src=0, next = DECODE.
  - Otherwise stay in FETCH with mem_read held high.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target captured into ALUOut).
  - Next = EXEC for a supported opcode.
  - Otherwise next = HALT and illegal_o is set.
- EXEC:
  - R: alu_src_a=1, alu_src_b=00, alu_op=10; next = WB.
  - I-ALU: alu_src_a=1, alu_src_b=10, alu_op=10; next = WB.
  - LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00; next = MEM.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero_i; next = FETCH; instruction retires.
- MEM:
  - iord=1.
  - LOAD: mem_read=1; on mem_ready_i, next = WB.
  - STORE: mem_write=1; on mem_ready_i, next = FETCH and instruction retires.
  - Without mem_ready_i, stay in MEM with the request held.
- WB:
  - reg_write=1, mem_to_reg = (opcode==LOAD); next = FETCH; instruction retires.
- HALT: all enables 0. Stays in HALT until reset; illegal_o=1.
- retired_o increments by 1 on each retiring cycle and wraps modulo 2^CNT_W.
- mem_ready_i is ignored when neither mem_read_o nor mem_write_o is asserted.

## Timing
- Reset (nrst_i=0) takes effect immediately, asynchronously. state=FETCH, retired_o=0, illegal_o=0.
- After reset, mem_read_o=1 and iord_o=0; all other enables are 0.
- Reset asserted mid-instruction abandons the instruction, with no retire and no writes afterward.
- State and counter update on the rising edge of clk_i.
- Outputs are combinational from state and opcode_i. Three are also gated by inputs in the same cycle:
  - FETCH ir_write/pc_write are gated by mem_ready_i.
  - EXEC pc_write is gated by zero_i.
  - No registered output delay.
- Cycle counts with zero wait states (mem_ready_i=1 on first request):
  - BRANCH: 3.
  - STORE: 4.
  - R and I-ALU: 4.
  - LOAD: 5.
- Each cycle mem_ready_i is low adds one cycle to FETCH or MEM.
- Memory request holds stable (address select and read/write) until the ready cycle inclusive, then drops.
- A retire and a state change coincide on the same edge.

## Test plan
- Reset: hold nrst_i=0 mid-EXEC and release asynchronously → state_o=0, retired_o=0, illegal_o=0, mem_read_o=1, iord_o=0.
- R-type with mem_ready_i tied 1 → state sequence 0,1,2,4,0. reg_write_o=1 only in WB, mem_to_reg_o=0 there. retired_o +1 after 4 cycles.
- LOAD with mem_ready_i low 2 cycles in FETCH and 3 cycles in MEM:
  - Total 10 cycles.
  - mem_read_o stays high throughout both waits.
  - iord_o=1 only in MEM.
  - mem_to_reg_o=1 in WB.
- BRANCH twice:
  - zero_i=1 → pc_write_o=1, pc_src_o=1 in EXEC.
  - zero_i=0 → pc_write_o=0.
  - Both return to FETCH after 3 cycles; retired_o +2.
- Illegal opcode 1111111 in DECODE → HALT (state_o=5), illegal_o=1, no enables for 20 cycles, retired_o unchanged. Reset clears it.
- Counter wrap with CNT_W=4: retire 17 instructions (mixed STORE/BRANCH) → retired_o=1.
